// File: rtl/mealy_pkg.sv
// Shared types and elaboration-time helpers for the Mealy pattern detector.
// kmp_next builds the next-state table for a fixed pattern.
package mealy_pkg;

  localparam int unsigned KMP_MAX_LEN = 64;
  localparam int unsigned KMP_IDX_W   = 6;

  typedef logic [KMP_MAX_LEN-1:0] pat_t;
  typedef logic [KMP_IDX_W-1:0]   state_idx_t;

  // Longest j < len such that the last j received bits (prefix[0..state-1], then b)
  // equal pattern[0..j-1]. A full-length hit therefore yields F(len).
  function automatic state_idx_t kmp_next(input pat_t pattern, input int unsigned len,
                                          input state_idx_t state, input logic b);
    pat_t        seq;
    int unsigned k;
    int unsigned best;
    int unsigned base;
    logic        ok;
    k        = 32'(state);
    best     = 0;
    seq      = pattern;
    seq[k]   = b;
    for (int unsigned j = 1; j < KMP_MAX_LEN; j++) begin
      if (k < len && j <= k + 1 && j < len) begin
        base = k + 1 - j;
        ok   = 1'b1;
        for (int unsigned i = 0; i < KMP_MAX_LEN; i++) begin
          if (i < j) begin
            if (seq[base + i] != pattern[i]) ok = 1'b0;
          end
        end
        if (ok) best = j;
      end
    end
    return state_idx_t'(best);
  endfunction

endpackage

// File: rtl/mealy_match_counter.sv
// Saturating match counter, present only when MEALY_MATCH_CNT_EN is defined.
`ifdef MEALY_MATCH_CNT_EN
module mealy_match_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         Resetn,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule
`endif

// File: rtl/mealy_pattern_detector.sv
// Parametrised Mealy serial pattern detector with overlap/non-overlap modes.
// Optional saturating match counter enabled by MEALY_MATCH_CNT_EN.
module mealy_pattern_detector
  import mealy_pkg::*;
#(
  parameter int unsigned          PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0]   PATTERN = 4'b1011,
  parameter bit                   OVERLAP = 1'b1
`ifdef MEALY_MATCH_CNT_EN
  ,
  parameter int unsigned          MATCH_CNT_W = 8
`endif
) (
  input  logic                       clk,
  input  logic                       Resetn,
  input  logic                       en,
  input  logic                       w,
  input  logic                       clear,
  output logic                       z,
  output logic [$clog2(PAT_LEN)-1:0] state_o
`ifdef MEALY_MATCH_CNT_EN
  ,
  output logic [MATCH_CNT_W-1:0]     match_cnt
`endif
);

  localparam int unsigned    SW        = $clog2(PAT_LEN);
  localparam int unsigned    NUM_CODES = 2 ** SW;
  localparam logic [SW-1:0]  LAST      = SW'(PAT_LEN - 1);
  localparam pat_t           PAT_PAD   = pat_t'(PATTERN);

  logic [SW-1:0] state;
  logic [SW-1:0] state_nxt;
  logic [SW-1:0] nxt_tab [NUM_CODES][2];

  // Next-state table; unused encodings fall back to S0 via kmp_next.
  for (genvar s = 0; s < NUM_CODES; s++) begin : g_state
    for (genvar b = 0; b < 2; b++) begin : g_bit
      localparam bit         LAST_HIT = (s == int'(PAT_LEN) - 1) && (PAT_PAD[s] == 1'(b));
      localparam state_idx_t NXT      = kmp_next(PAT_PAD, PAT_LEN, state_idx_t'(s), 1'(b));
      assign nxt_tab[s][b] = (LAST_HIT && !OVERLAP) ? '0 : SW'(NXT);
    end
  end

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      state <= '0;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    z         = 1'b0;
    if (clear) begin
      state_nxt = '0;
    end else if (en) begin
      state_nxt = nxt_tab[state][w];
      z         = Resetn && (state == LAST) && (w == PATTERN[PAT_LEN-1]);
    end
  end

  assign state_o = state;

`ifdef MEALY_MATCH_CNT_EN
  mealy_match_counter #(
    .W(MATCH_CNT_W)
  ) u_match_counter (
    .clk    (clk),
    .Resetn (Resetn),
    .clear  (clear),
    .inc    (z),
    .count  (match_cnt)
  );
`endif

endmodule
